// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane width
// and the alignment rule used at request acceptance.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam int LANE_W = 8;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:       bad = off[0];
      SZ_W, SZ_D: bad = (off != 2'b00);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends load data from a memory entry,
// and merges right-aligned store data into the selected lanes of an entry.
module lsu_lane
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [4:0]        shamt;
  logic [31:0]       field;
  logic [DATA_W-1:0] mask;

  always_comb begin
    shamt  = 5'(offset_i * LANE_W);
    field  = 32'(rdata_i >> shamt);
    load_o = rdata_i;
    mask   = '1;
    case (size_i)
      SZ_B: begin
        load_o = {{(DATA_W-8){signed_i & field[7]}}, field[7:0]};
        mask   = DATA_W'(8'hFF);
      end
      SZ_H: begin
        load_o = {{(DATA_W-16){signed_i & field[15]}}, field[15:0]};
        mask   = DATA_W'(16'hFFFF);
      end
      SZ_W: begin
        load_o = {{(DATA_W-32){signed_i & field[31]}}, field[31:0]};
        mask   = DATA_W'(32'hFFFF_FFFF);
      end
      default: ;
    endcase
    // Doubles are always aligned, so shamt is zero and the merge degenerates to wdata.
    merge_o = (rdata_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time, performs loads and
// read-modify-write sub-double stores against a single-entry-wide data memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] Write_d,
  input  logic [DATA_W-1:0] Read_d
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              store_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              resp_valid_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merge;

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .size_i  (size_q),
    .signed_i(sgn_q),
    .offset_i(addr_q[1:0]),
    .rdata_i (Read_d),
    .wdata_i (wdata_q),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  // Gated with rst_n so the unit never advertises readiness while held in reset.
  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign MemRead    = mem_rd_q;
  assign MemWrite   = mem_wr_q;
  assign address    = addr_q;
  assign Write_d    = wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      store_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            store_q <= req_is_store;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (misaligned(req_size, req_addr[1:0])) begin
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (req_is_store && (req_size == SZ_D)) begin
              wr_data_q <= req_wdata;
              mem_wr_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          // Read_d carries the entry this cycle only; capture it now.
          if (store_q) begin
            wr_data_q <= lane_merge;
            mem_wr_q  <= 1'b1;
            state_q   <= S_WR;
          end else begin
            rdata_q      <= lane_load;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read data memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] address;
  logic [63:0] Write_d;
  logic [63:0] Read_d = '0;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [63:0] last_wd = '0;
  logic [63:0] mem [0:31];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .Write_d(Write_d), .Read_d(Read_d)
  );

  always @(posedge clk) begin
    Read_d <= MemRead ? mem[address[7:3]] : 64'h0;
    if (MemWrite) mem[address[7:3]] <= Write_d;
  end

  always @(posedge clk) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) begin
      wr_cnt++;
      last_wd = Write_d;
    end
    if (MemRead && MemWrite) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one operation and returns once resp_valid is seen (response left pending).
  task automatic do_op(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic e, output int lat);
    int n;
    rd_cnt = 0;
    wr_cnt = 0;
    req_is_store = st;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL op_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, lat);
    end
    rd = resp_rdata;
    e = resp_err;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {req_ready, resp_valid, resp_err, MemRead, MemWrite});
    end
    checks++;
    if ((address | Write_d | resp_rdata) !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wd=%h rdata=%h required all 0", address, Write_d, resp_rdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_double_store_load();
    logic [63:0] rd; logic e; int lat;
    do_op(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, rd, e, lat);
    checks++;
    if (lat !== 2 || wr_cnt !== 1 || rd_cnt !== 0 || rd !== 64'h0) begin
      failures++;
      $display("FAIL dstore: got lat=%0d wr=%0d rd=%0d rdata=%h required lat=2 wr=1 rd=0 rdata=0", lat, wr_cnt, rd_cnt, rd);
    end
    consume();
    do_op(1'b0, 2'b11, 1'b1, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'h1122334455667788 || e !== 1'b0) begin
      failures++;
      $display("FAIL dload_data: got %h err=%b required 1122334455667788 err=0", rd, e);
    end
    checks++;
    if (lat !== 3 || rd_cnt !== 1 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL dload_lat: got lat=%0d rd=%0d wr=%0d required lat=3 rd=1 wr=0", lat, rd_cnt, wr_cnt);
    end
    consume();
  endtask

  task automatic test_byte_rmw();
    logic [63:0] rd; logic e; int lat;
    do_op(1'b1, 2'b00, 1'b1, 64'h41, 64'hFFFFFFFFFFFFFFAB, rd, e, lat);
    checks++;
    if (rd_cnt !== 1 || wr_cnt !== 1 || last_wd !== 64'h112233445566AB88) begin
      failures++;
      $display("FAIL byte_rmw: got rd=%0d wr=%0d Write_d=%h required 1 1 112233445566AB88", rd_cnt, wr_cnt, last_wd);
    end
    checks++;
    if (lat !== 4 || rd !== 64'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_rmw_resp: got lat=%0d rdata=%h err=%b required 4 0 0", lat, rd, e);
    end
    consume();
  endtask

  task automatic test_signed_loads();
    logic [63:0] rd; logic e; int lat;
    do_op(1'b1, 2'b11, 1'b0, 64'h40, 64'h00000000000080FF, rd, e, lat);
    consume();
    do_op(1'b0, 2'b01, 1'b1, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFF80FF) begin
      failures++;
      $display("FAIL half_signed: got %h required FFFFFFFFFFFF80FF", rd);
    end
    consume();
    do_op(1'b0, 2'b00, 1'b0, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'h00000000000000FF) begin
      failures++;
      $display("FAIL byte_unsigned: got %h required 00000000000000FF", rd);
    end
    consume();
    do_op(1'b0, 2'b00, 1'b1, 64'h41, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF80) begin
      failures++;
      $display("FAIL byte_signed_hi: got %h required FFFFFFFFFFFFFF80", rd);
    end
    consume();
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic e; int lat;
    both_cnt = 0;
    do_op(1'b0, 2'b10, 1'b0, 64'h42, 64'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 64'h0 || lat !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL misaligned_word: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d required 1 0 1 0 0", e, rd, lat, rd_cnt, wr_cnt);
    end
    consume();
    do_op(1'b1, 2'b01, 1'b0, 64'h41, 64'h5555, rd, e, lat);
    checks++;
    if (e !== 1'b1 || lat !== 1 || wr_cnt !== 0 || rd_cnt !== 0 || mem[8] !== 64'h00000000000080FF) begin
      failures++;
      $display("FAIL misaligned_half_store: got err=%b lat=%0d wr=%0d entry=%h required 1 1 0 00000000000080FF", e, lat, wr_cnt, mem[8]);
    end
    consume();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL strobe_overlap: got %0d cycles with both strobes required 0", both_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic e; int lat; int bad;
    do_op(1'b0, 2'b10, 1'b0, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'h00000000000080FF) begin
      failures++;
      $display("FAIL word_unsigned: got %h required 00000000000080FF", rd);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h00000000000080FF || resp_err !== 1'b0 || req_ready !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold: got %0d unstable cycles required 0", bad);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic e; int lat;
    do_op(1'b1, 2'b01, 1'b0, 64'h42, 64'h0000000000001234, rd, e, lat);
    consume();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready: got ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
    do_op(1'b0, 2'b10, 1'b1, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'h00000000123480FF) begin
      failures++;
      $display("FAIL b2b_half_merge: got %h required 00000000123480FF", rd);
    end
    consume();
    do_op(1'b1, 2'b10, 1'b0, 64'h40, 64'h0000000089ABCDEF, rd, e, lat);
    consume();
    do_op(1'b0, 2'b10, 1'b1, 64'h40, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'hFFFFFFFF89ABCDEF) begin
      failures++;
      $display("FAIL word_signed: got %h required FFFFFFFF89ABCDEF", rd);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] rd; logic e; int lat;
    do_op(1'b1, 2'b11, 1'b0, 64'h48, 64'hCAFEBABEDEADBEEF, rd, e, lat);
    consume();
    wr_cnt = 0;
    req_is_store = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 64'h48; req_wdata = 64'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (MemRead !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_rd_phase: got MemRead=%b ready=%b required 1 0", MemRead, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({MemRead, MemWrite, resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL abort_outputs: got %b required 000", {MemRead, MemWrite, resp_valid});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_cnt !== 0 || mem[9] !== 64'hCAFEBABEDEADBEEF || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_entry: got wr=%0d entry=%h valid=%b required 0 CAFEBABEDEADBEEF 0", wr_cnt, mem[9], resp_valid);
    end
    do_op(1'b0, 2'b11, 1'b0, 64'h48, 64'h0, rd, e, lat);
    checks++;
    if (rd !== 64'hCAFEBABEDEADBEEF) begin
      failures++;
      $display("FAIL abort_reload: got %h required CAFEBABEDEADBEEF", rd);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_double_store_load();
    test_byte_rmw();
    test_signed_loads();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, data width and memory entry width.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline offers a memory operation.
REQ-005 req_ready  output  1  LSU accepts the operation; high only in IDLE.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-008 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  ADDR_W  byte address of the access.
REQ-010 req_wdata  input  DATA_W  store data, right-aligned.
REQ-011 resp_valid  output  1  operation complete; resp_rdata and resp_err are valid.
REQ-012 resp_ready  input  1  pipeline consumes the response.
REQ-013 resp_rdata  output  DATA_W  extended load data; zero for stores and errors.
REQ-014 resp_err  output  1  misaligned access; no memory access was made.
REQ-015 MemRead  output  1  read strobe to the data memory.
REQ-016 MemWrite  output  1  write strobe to the data memory.
REQ-017 address  output  ADDR_W  memory address; equals the latched req_addr.
REQ-018 Write_d  output  DATA_W  memory write data.
REQ-019 Read_d  input  DATA_W  memory read data, registered by the memory one cycle after MemRead and zero otherwise.

Function
REQ-020 A handshake SHALL occur when req_valid && req_ready; the LSU SHALL latch addr, size, signed, is_store and wdata on that edge.
REQ-021 Lane offset SHALL be req_addr[1:0]; byte lane shift = offset*8 bits within the 64-bit entry.
REQ-022 Misalignment rules:
- half with addr[0]=1 is misaligned;
- word or double with addr[1:0]!=0 is misaligned.
REQ-023 FSM states SHALL be IDLE, RD, CAP, WR, RESP.
REQ-024 IDLE transitions on handshake:
- misaligned -> RESP with resp_err=1;
- double store -> WR;
- anything else -> RD.
REQ-025 RD SHALL assert MemRead for exactly one cycle, then go to CAP.
REQ-026 CAP SHALL sample Read_d.
- Load: register the extracted, extended data into resp_rdata, then -> RESP.
- Sub-double store: register merged data (entry with only the selected lanes replaced), then -> WR.
REQ-027 WR SHALL assert MemWrite for exactly one cycle with Write_d = merged data (or req_wdata for double), then -> RESP.
REQ-028 RESP SHALL hold resp_valid=1 and all response outputs stable until resp_ready=1, then -> IDLE.
REQ-029 Latency from handshake edge to first resp_valid cycle SHALL be:
- load: 3 cycles;
- sub-double store: 4 cycles;
- double store: 2 cycles;
- error: 1 cycle.
REQ-030 MemRead and MemWrite SHALL never both be high, and SHALL be low in IDLE, CAP and RESP.
REQ-031 Back-to-back operations: req_ready SHALL rise in the cycle after the resp_valid/resp_ready handshake; no request overlaps a pending response.
REQ-032 Double loads SHALL return Read_d unmodified; req_signed SHALL be ignored for stores and doubles.

Reset
REQ-033 While rst_n=0, the state SHALL be IDLE and all outputs zero except req_ready, which SHALL be 1 once rst_n=1.
REQ-034 Reset asserted mid-operation SHALL abort it immediately: no strobe remains asserted, no response is produced, and a partially read-modify-written entry is left unwritten.

Structure
REQ-035 Size encodings, state encoding and lane width SHALL live in params.vh.
REQ-036 Lane extract/sign-extend and lane merge SHALL be one combinational sub-module, lsu_lane; the FSM stays in load_store_unit.

Verification
REQ-037 Double store then double load:
- store 0x1122334455667788 to 0x40; load 0x40 -> resp_rdata=0x1122334455667788, resp_err=0;
- load resp_valid 3 cycles after the handshake.
REQ-038 Byte store read-modify-write:
- entry 0x40 = 0x1122334455667788; store byte 0xAB at 0x41;
- -> exactly one MemRead then one MemWrite with Write_d=0x112233445566AB88.
REQ-039 Signed loads from entry 0x..80FF:
- half signed at 0x40 -> 0xFFFFFFFFFFFF80FF;
- byte unsigned at 0x40 -> 0xFF;
- byte signed at 0x41 -> 0xFFFFFFFFFFFFFF80.
REQ-040 Misaligned word load at 0x42 -> resp_err=1 and resp_rdata=0 one cycle after the handshake; MemRead and MemWrite never asserted.
REQ-041 Backpressure and reset:
- hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0;
- pull rst_n low in the WR-pending (CAP) cycle -> MemWrite stays 0 and the entry is unchanged.
